// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: state encoding,
// default reset PC and a word-alignment helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StHold  = 2'd1,
      StDrain = 2'd2
   } fetch_state_e;

   localparam logic [31:0] ResetPcDefault = 32'h0000_3000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory handshake, decode handoff and redirect.
interface fetch_ctrl_if;

   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;

   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   logic        redir_valid;
   logic [31:0] redir_pc;

   modport master (
      output im_req, im_addr, if_valid, if_instr, if_pc,
      input  im_ack, im_rdata, if_ready, redir_valid, redir_pc
   );

   modport slave (
      input  im_req, im_addr, if_valid, if_instr, if_pc,
      output im_ack, im_rdata, if_ready, redir_valid, redir_pc
   );

endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding-request instruction fetch controller with redirect
// handling; a redirect kills any in-flight or held instruction.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ResetPcDefault
) (
   input logic          clk,
   input logic          reset,
   fetch_ctrl_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  redir_tgt;

   assign redir_tgt = align_word(bus.redir_pc);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StFetch;
         pc_q       <= RESET_PC + 32'd4;
         req_addr_q <= RESET_PC;
         instr_q    <= '0;
         if_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      if_pc_d    = if_pc_q;
      unique case (state_q)
         StFetch: begin
            if (bus.redir_valid) begin
               pc_d = redir_tgt;
               // Without an ack the old request must still complete, so drain it.
               if (bus.im_ack) req_addr_d = redir_tgt;
               else            state_d    = StDrain;
            end else if (bus.im_ack) begin
               instr_d = bus.im_rdata;
               if_pc_d = req_addr_q;
               // pc follows the word just accepted; wraps naturally at 2^32.
               pc_d    = req_addr_q + 32'd4;
               state_d = StHold;
            end
         end
         StHold: begin
            if (bus.redir_valid) begin
               pc_d       = redir_tgt;
               req_addr_d = redir_tgt;
               state_d    = StFetch;
            end else if (bus.if_ready) begin
               req_addr_d = pc_q;
               state_d    = StFetch;
            end
         end
         StDrain: begin
            if (bus.redir_valid) begin
               pc_d = redir_tgt;
               if (bus.im_ack) begin
                  req_addr_d = redir_tgt;
                  state_d    = StFetch;
               end
            end else if (bus.im_ack) begin
               req_addr_d = pc_q;
               state_d    = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   // Outputs are gated by reset so the reset cycle never requests or presents.
   assign bus.im_req   = reset & ((state_q == StFetch) | (state_q == StDrain));
   assign bus.im_addr  = req_addr_q;
   assign bus.if_valid = reset & (state_q == StHold);
   assign bus.if_instr = instr_q;
   assign bus.if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: memory responses are driven by
// hand and each delivered word is checked against the expected queue.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;
   item_t sb_q[$];
   item_t exp_item;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_PC(ResetPcDefault)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] a);
      sb_q.push_back('{pc: a, instr: mem_word(a)});
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      bus.im_ack = 1'b0;
      bus.redir_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.im_ack = 1'b0;
      step();
      n_total++;
      if ({bus.im_req, bus.if_valid} !== 2'b00)
         $display("FAIL reset_req_valid: got %b want 00", {bus.im_req, bus.if_valid});
      else n_pass++;
      n_total++;
      if ({bus.if_pc, bus.if_instr} !== 64'd0)
         $display("FAIL reset_if_regs: got %h want 0", {bus.if_pc, bus.if_instr});
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({bus.im_req, bus.im_addr} !== {1'b1, 32'h0000_3000})
         $display("FAIL reset_first_req: got %b/%h want 1/00003000", bus.im_req, bus.im_addr);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] a;
      for (int i = 0; i < 3; i++) begin
         a = 32'h0000_3000 + 32'(4 * i);
         n_total++;
         if ({bus.im_req, bus.im_addr} !== {1'b1, a})
            $display("FAIL stream_addr%0d: got %b/%h want 1/%h", i, bus.im_req, bus.im_addr, a);
         else n_pass++;
         bus.im_ack = 1'b1;
         bus.im_rdata = mem_word(a);
         push_exp(a);
         step();
         bus.im_ack = 1'b0;
         exp_item = sb_q.pop_front();
         n_total++;
         if ({bus.if_valid, bus.im_req, bus.if_pc, bus.if_instr} !== {2'b10, exp_item})
            $display("FAIL stream_out%0d: got %b%b %h/%h want 10 %h/%h", i, bus.if_valid,
                     bus.im_req, bus.if_pc, bus.if_instr, exp_item.pc, exp_item.instr);
         else n_pass++;
         bus.if_ready = 1'b1;
         step();
      end
   endtask

   task automatic test_delay();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if ({bus.im_req, bus.if_valid, bus.im_addr} !== {2'b10, 32'h0000_3000})
            $display("FAIL delay_hold%0d: got %b%b/%h want 10/00003000", k, bus.im_req,
                     bus.if_valid, bus.im_addr);
         else n_pass++;
         if (k == 3) begin
            bus.im_ack = 1'b1;
            bus.im_rdata = mem_word(32'h0000_3000);
            push_exp(32'h0000_3000);
         end
         step();
      end
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL delay_out: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      bus.if_ready = 1'b1;
      step();
   endtask

   task automatic test_stall();
      bus.if_ready = 1'b0;
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3004);
      push_exp(32'h0000_3004);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         n_total++;
         if ({bus.if_valid, bus.im_req, bus.if_pc, bus.if_instr} !== {2'b10, exp_item})
            $display("FAIL stall%0d: got %b%b %h/%h want 10 %h/%h", k, bus.if_valid,
                     bus.im_req, bus.if_pc, bus.if_instr, exp_item.pc, exp_item.instr);
         else n_pass++;
         step();
      end
      bus.if_ready = 1'b1;
      step();
      n_total++;
      if ({bus.im_req, bus.if_valid, bus.im_addr} !== {2'b10, 32'h0000_3008})
         $display("FAIL stall_release: got %b%b/%h want 10/00003008", bus.im_req,
                  bus.if_valid, bus.im_addr);
      else n_pass++;
   endtask

   task automatic test_redirect_drain();
      apply_reset();
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3000);
      step();
      bus.im_ack = 1'b0;
      step();
      bus.redir_valid = 1'b1;
      bus.redir_pc = 32'h0000_3100;
      step();
      bus.redir_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if ({bus.im_req, bus.if_valid, bus.im_addr} !== {2'b10, 32'h0000_3004})
            $display("FAIL drain_hold%0d: got %b%b/%h want 10/00003004", k, bus.im_req,
                     bus.if_valid, bus.im_addr);
         else n_pass++;
         step();
      end
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3004);
      step();
      n_total++;
      if ({bus.im_req, bus.if_valid, bus.im_addr} !== {2'b10, 32'h0000_3100})
         $display("FAIL drain_exit: got %b%b/%h want 10/00003100", bus.im_req, bus.if_valid,
                  bus.im_addr);
      else n_pass++;
      bus.im_rdata = mem_word(32'h0000_3100);
      push_exp(32'h0000_3100);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL drain_target: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      bus.if_ready = 1'b1;
      step();
      n_total++;
      if (bus.im_addr !== 32'h0000_3104)
         $display("FAIL drain_next: got %h want 00003104", bus.im_addr);
      else n_pass++;
   endtask

   task automatic test_redirect_hold();
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3104);
      step();
      bus.im_ack = 1'b0;
      bus.redir_valid = 1'b1;
      bus.redir_pc = 32'h0000_3203;
      bus.if_ready = 1'b1;
      step();
      bus.redir_valid = 1'b0;
      n_total++;
      if ({bus.if_valid, bus.im_req, bus.im_addr} !== {2'b01, 32'h0000_3200})
         $display("FAIL hold_redir: got %b%b/%h want 01/00003200", bus.if_valid, bus.im_req,
                  bus.im_addr);
      else n_pass++;
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3200);
      push_exp(32'h0000_3200);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL hold_target: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      step();
   endtask

   task automatic test_last_redirect_wins();
      bus.redir_valid = 1'b1;
      bus.redir_pc = 32'h0000_3300;
      step();
      bus.redir_pc = 32'h0000_3400;
      step();
      bus.redir_valid = 1'b0;
      n_total++;
      if ({bus.im_req, bus.im_addr} !== {1'b1, 32'h0000_3204})
         $display("FAIL double_drain: got %b/%h want 1/00003204", bus.im_req, bus.im_addr);
      else n_pass++;
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3204);
      step();
      n_total++;
      if ({bus.if_valid, bus.im_req, bus.im_addr} !== {2'b01, 32'h0000_3400})
         $display("FAIL double_target: got %b%b/%h want 01/00003400", bus.if_valid,
                  bus.im_req, bus.im_addr);
      else n_pass++;
      bus.im_rdata = mem_word(32'h0000_3400);
      push_exp(32'h0000_3400);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL double_out: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      step();
   endtask

   task automatic test_redirect_fetch_ack();
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3404);
      bus.redir_valid = 1'b1;
      bus.redir_pc = 32'hFFFF_FFFF;
      step();
      bus.redir_valid = 1'b0;
      bus.im_ack = 1'b0;
      n_total++;
      if ({bus.if_valid, bus.im_req, bus.im_addr} !== {2'b01, 32'hFFFF_FFFC})
         $display("FAIL fetch_ack_redir: got %b%b/%h want 01/fffffffc", bus.if_valid,
                  bus.im_req, bus.im_addr);
      else n_pass++;
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL wrap_out: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      step();
      n_total++;
      if ({bus.im_req, bus.im_addr} !== {1'b1, 32'h0000_0000})
         $display("FAIL wrap_addr: got %b/%h want 1/00000000", bus.im_req, bus.im_addr);
      else n_pass++;
   endtask

   task automatic test_reset_drain();
      bus.redir_valid = 1'b1;
      bus.redir_pc = 32'h0000_3100;
      step();
      bus.redir_valid = 1'b0;
      reset = 1'b0;
      step();
      n_total++;
      if ({bus.im_req, bus.if_valid} !== 2'b00)
         $display("FAIL drain_reset: got %b%b want 00", bus.im_req, bus.if_valid);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({bus.im_req, bus.im_addr} !== {1'b1, 32'h0000_3000})
         $display("FAIL drain_reset_addr: got %b/%h want 1/00003000", bus.im_req, bus.im_addr);
      else n_pass++;
      bus.im_ack = 1'b1;
      bus.im_rdata = mem_word(32'h0000_3000);
      push_exp(32'h0000_3000);
      step();
      bus.im_ack = 1'b0;
      exp_item = sb_q.pop_front();
      n_total++;
      if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, exp_item})
         $display("FAIL drain_reset_out: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_pc,
                  bus.if_instr, exp_item.pc, exp_item.instr);
      else n_pass++;
      n_total++;
      if (sb_q.size() != 0)
         $display("FAIL sb_leftover: got %0d want 0", sb_q.size());
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      bus.im_ack = 1'b0;
      bus.im_rdata = '0;
      bus.if_ready = 1'b1;
      bus.redir_valid = 1'b0;
      bus.redir_pc = '0;
      test_reset();
      test_stream();
      test_delay();
      test_stall();
      test_redirect_drain();
      test_redirect_hold();
      test_last_redirect_wins();
      test_redirect_fetch_ack();
      test_reset_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low (0 = reset, sampled on the clk rising edge).
REQ-004 The block SHALL have the following instruction-memory ports:
- im_req, output, 1 bit: fetch request.
- im_addr, output, 32 bits: fetch address.
- im_ack, input, 1 bit: memory response valid.
- im_rdata, input, 32 bits: instruction word, valid when im_ack is 1.
REQ-005 The block SHALL have the following decode-side ports:
- if_valid, output, 1 bit: instruction available.
- if_instr, output, 32 bits: instruction word.
- if_pc, output, 32 bits: address of if_instr.
- if_ready, input, 1 bit: decode accepts this cycle.
REQ-006 The block SHALL have the following redirect ports:
- redir_valid, input, 1 bit: branch/jump redirect.
- redir_pc, input, 32 bits: redirect target.

Function
REQ-007 The block SHALL implement three states with these outputs:
- FETCH: im_req=1.
- HOLD: if_valid=1, im_req=0.
- DRAIN: im_req=1, response discarded.
REQ-008 The block SHALL keep an internal pc register (next address to fetch) and a req_addr register; im_addr SHALL equal req_addr whenever im_req=1.
REQ-009 im_addr SHALL be held stable while im_req=1 until the cycle im_ack=1; a request once issued is never withdrawn.
REQ-010 In FETCH, the block SHALL take the following action on im_ack=1 with redir_valid=0:
- Capture im_rdata into if_instr and req_addr into if_pc.
- Set pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Go to HOLD.
REQ-011 Latency: im_ack at cycle N SHALL give if_valid=1 at cycle N+1; if_instr and if_pc SHALL stay stable while if_valid=1 and if_ready=0.
REQ-012 In HOLD, if_ready=1 SHALL move the block to FETCH next cycle, with req_addr <= pc.
REQ-013 redir_valid SHALL be highest priority in every state. Redirect targets SHALL have bits [1:0] forced to 0.
REQ-014 A redirect in FETCH with im_ack=1 SHALL discard im_rdata and set pc, req_addr <= redir_pc; the state SHALL stay FETCH.
REQ-015 A redirect in FETCH with im_ack=0 SHALL do the following:
- Set pc <= redir_pc.
- Go to DRAIN, keeping the old req_addr and im_req=1.
REQ-016 In DRAIN, on im_ack=1 the block SHALL discard im_rdata, set req_addr <= pc, and go to FETCH. A further redirect during DRAIN SHALL overwrite pc; the last redirect wins.
REQ-017 A redirect in HOLD SHALL do the following:
- Drop if_valid next cycle; the held instruction is killed, even if if_ready=1 in the same cycle.
- Set pc, req_addr <= redir_pc.
- Go to FETCH.
REQ-018 No instruction fetched before a redirect SHALL ever appear on if_valid after that redirect cycle.

Reset
REQ-019 While reset=0 at a clock edge, the block SHALL set the following:
- state <= FETCH.
- pc <= RESET_PC+4.
- req_addr <= RESET_PC.
- if_instr, if_pc <= 0.
REQ-020 During the reset cycle, im_req and if_valid SHALL be 0. The first request SHALL issue in the first cycle after reset returns to 1.
REQ-021 Reset asserted mid-operation, in any state including DRAIN, SHALL abandon any outstanding request without waiting for im_ack; the memory is reset by the same signal.

Structure
REQ-022 The state encodings (FETCH/HOLD/DRAIN) and the RESET_PC default SHALL live in a shared constants package/header, fetch_pkg, used by fetch_ctrl and its testbench.
REQ-023 fetch_ctrl SHALL be a single module with no sub-modules. The instruction memory SHALL be external and connected through the im_* handshake.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset then 1-cycle-ack memory, if_ready=1 -> im_addr 0x3000, 0x3004, 0x3008; if_pc matches with 1-cycle latency, one instruction per 2 cycles.
- Memory ack delayed 3 cycles -> im_addr held at 0x3000 for all 4 request cycles; if_valid 1 cycle after ack.
- if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc constant, im_req=0 throughout.
- redir_valid, redir_pc=0x3100 while request 0x3004 outstanding -> DRAIN until ack, word from 0x3004 never valid, next im_addr 0x3100.
- redir_valid, redir_pc=0x3203, in HOLD with if_ready=1 -> held instruction dropped, next im_addr 0x3200.
- reset=0 during DRAIN -> next cycle im_req=0, if_valid=0; after release im_addr 0x3000.
